// File: rtl/mxu_pkg.sv
// Shared constants and types for the 2x2 output-stationary matrix unit and its sequencer.
package mxu_pkg;

  localparam int unsigned NUM_SIZE  = 16;
  localparam int unsigned GRID_SIZE = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } mxu_ctrl_state_t;

  // Cycles needed after the last beat for the skewed wavefront to reach the far corner PE.
  function automatic int unsigned drain_cycles(input int unsigned grid);
    return 2 * (grid - 1);
  endfunction

  localparam int unsigned DRAIN_CYCLES = drain_cycles(GRID_SIZE);

endpackage

// File: rtl/skew_line.sv
// ce-enabled delay line used to skew one array lane; DEPTH=0 degenerates to a wire.
module skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, ce, clr};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int n = 0; n < int'(DEPTH); n++) stage_q[n] <= '0;
      end else if (clr) begin
        for (int n = 0; n < int'(DEPTH); n++) stage_q[n] <= '0;
      end else if (ce) begin
        stage_q[0] <= d;
        for (int n = 1; n < int'(DEPTH); n++) stage_q[n] <= stage_q[n-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/mxu_ctrl.sv
// Sequencer for one C = A*B product on the systolic mxu: clear, feed K skewed beats, drain,
// capture the tile and hand it out over a valid/ready handshake.
module mxu_ctrl #(
  parameter int unsigned NUM_SIZE  = mxu_pkg::NUM_SIZE,
  parameter int unsigned GRID_SIZE = mxu_pkg::GRID_SIZE,
  parameter int unsigned K_W       = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [K_W-1:0]                      k_len,
  output logic                                busy,
  input  logic                                a_valid,
  output logic                                a_ready,
  input  logic [NUM_SIZE*GRID_SIZE-1:0]       a_data,
  input  logic [NUM_SIZE*GRID_SIZE-1:0]       b_data,
  output logic                                mxu_ce,
  output logic                                mxu_clr,
  output logic [NUM_SIZE*GRID_SIZE-1:0]       mxu_west,
  output logic [NUM_SIZE*GRID_SIZE-1:0]       mxu_north,
  input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] mxu_result,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] res_data
);

  import mxu_pkg::*;

  localparam int unsigned LANE_W    = NUM_SIZE * GRID_SIZE;
  localparam int unsigned DRAIN_LEN = drain_cycles(GRID_SIZE);
  localparam logic [2:0]  DRAIN_LAST = 3'(DRAIN_LEN - 1);
  // A 1x1 array has no skew to flush, so the last beat goes straight to CAPTURE.
  localparam mxu_ctrl_state_t POST_FEED = (DRAIN_LEN == 0) ? CAPTURE : DRAIN;

  mxu_ctrl_state_t state_q, state_d;
  logic [K_W-1:0]  k_rem_q, k_rem_d;
  logic [2:0]      drain_cnt_q, drain_cnt_d;
  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] res_data_q;

  logic              xfer;
  logic              skew_clr;
  logic [LANE_W-1:0] west_in;
  logic [LANE_W-1:0] north_in;

  assign xfer     = (state_q == FEED) && a_valid;
  assign skew_clr = (state_q == CLEAR);
  assign west_in  = xfer ? a_data : '0;
  assign north_in = xfer ? b_data : '0;

  always_comb begin
    busy      = (state_q != IDLE);
    a_ready   = (state_q == FEED);
    mxu_clr   = (state_q == CLEAR);
    mxu_ce    = xfer || (state_q == DRAIN);
    res_valid = (state_q == DONE);
    res_data  = res_data_q;
  end

  always_comb begin
    state_d     = state_q;
    k_rem_d     = k_rem_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_rem_d = k_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        drain_cnt_d = '0;
        state_d     = (k_rem_q == '0) ? POST_FEED : FEED;
      end
      FEED: begin
        if (xfer) begin
          k_rem_d = k_rem_q - K_W'(1);
          if (k_rem_q == K_W'(1)) state_d = POST_FEED;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 3'd1;
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
          state_d     = CAPTURE;
        end
      end
      CAPTURE: state_d = DONE;
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_rem_q     <= '0;
      drain_cnt_q <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_rem_q     <= k_rem_d;
      drain_cnt_q <= drain_cnt_d;
      if (state_q == CAPTURE) res_data_q <= mxu_result;
    end
  end

  // Lane i is delayed by i ce-cycles so PE(i,j) meets A[i][k] and B[k][j] together.
  for (genvar i = 0; i < GRID_SIZE; i++) begin : g_lane
    skew_line #(
      .DEPTH(i),
      .WIDTH(NUM_SIZE)
    ) u_west (
      .clk(clk),
      .rst(rst),
      .ce (mxu_ce),
      .clr(skew_clr),
      .d  (west_in[i*NUM_SIZE +: NUM_SIZE]),
      .q  (mxu_west[i*NUM_SIZE +: NUM_SIZE])
    );

    skew_line #(
      .DEPTH(i),
      .WIDTH(NUM_SIZE)
    ) u_north (
      .clk(clk),
      .rst(rst),
      .ce (mxu_ce),
      .clr(skew_clr),
      .d  (north_in[i*NUM_SIZE +: NUM_SIZE]),
      .q  (mxu_north[i*NUM_SIZE +: NUM_SIZE])
    );
  end

endmodule

// File: tb/tb_mxu_ctrl.sv
// Directed bench for mxu_ctrl closed around a behavioural 2x2 mac array.
module tb_mxu_ctrl;

  localparam int NS = 16;
  localparam int G  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    k_len;
  logic          busy;
  logic          a_valid;
  logic          a_ready;
  logic [31:0]   a_data;
  logic [31:0]   b_data;
  logic          mxu_ce;
  logic          mxu_clr;
  logic [31:0]   mxu_west;
  logic [31:0]   mxu_north;
  logic [63:0]   mxu_result;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_cnt = 0;

  logic [31:0] a_beats [8];
  logic [31:0] b_beats [8];

  always #5 clk = ~clk;

  mxu_ctrl #(
    .NUM_SIZE (NS),
    .GRID_SIZE(G),
    .K_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_data    (b_data),
    .mxu_ce    (mxu_ce),
    .mxu_clr   (mxu_clr),
    .mxu_west  (mxu_west),
    .mxu_north (mxu_north),
    .mxu_result(mxu_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_ready) ready_cnt <= ready_cnt + 1;
  end

  // Behavioural 2x2 output-stationary array of mac PEs.
  logic [NS-1:0] acc_q   [G][G];
  logic [NS-1:0] east_q  [G][G];
  logic [NS-1:0] south_q [G][G];
  logic [NS-1:0] w_in    [G][G];
  logic [NS-1:0] n_in    [G][G];

  function automatic logic [15:0] mul16(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = x * y;
    return p[15:0];
  endfunction

  always_comb begin
    w_in[0][0] = mxu_west[15:0];
    w_in[0][1] = east_q[0][0];
    w_in[1][0] = mxu_west[31:16];
    w_in[1][1] = east_q[1][0];
    n_in[0][0] = mxu_north[15:0];
    n_in[0][1] = mxu_north[31:16];
    n_in[1][0] = south_q[0][0];
    n_in[1][1] = south_q[0][1];
    mxu_result = {acc_q[1][1], acc_q[1][0], acc_q[0][1], acc_q[0][0]};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < G; i++) begin
      for (int j = 0; j < G; j++) begin
        if (rst || mxu_clr) begin
          acc_q[i][j]   <= '0;
          east_q[i][j]  <= '0;
          south_q[i][j] <= '0;
        end else if (mxu_ce) begin
          acc_q[i][j]   <= acc_q[i][j] + mul16(w_in[i][j], n_in[i][j]);
          east_q[i][j]  <= w_in[i][j];
          south_q[i][j] <= n_in[i][j];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_c(input logic [15:0] c00, input logic [15:0] c01,
                                         input logic [15:0] c10, input logic [15:0] c11);
    return {c11, c10, c01, c00};
  endfunction

  // Beat k carries A column k (a0=A[0][k], a1=A[1][k]) and B row k (b0=B[k][0], b1=B[k][1]).
  task automatic set_beat(input int k, input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] b0, input logic [15:0] b1);
    a_beats[k] = {a1, a0};
    b_beats[k] = {b1, b0};
  endtask

  // Runs one product; returns latency (start cycle to first res_valid cycle, inclusive),
  // cycles from last accepted beat to res_valid, offset of first a_ready, ce seen in bubbles.
  task automatic run_product(input int k, input int stall_beat, input int stall_len,
                             input bit poke_start, output int lat, output int tail,
                             output int first_rdy, output int ce_bubble);
    int s, t, b, guard, bubbles;
    lat = 0; tail = 0; first_rdy = -1; ce_bubble = 0;
    bubbles = stall_len; b = 0; t = 0; guard = 0;
    @(negedge clk);
    start = 1'b1; k_len = 8'(k); s = cyc;
    @(negedge clk);
    start = 1'b0; k_len = 8'(k + 5);
    check("clear_clr", 64'(mxu_clr), 64'd1);
    check("clear_ce", 64'(mxu_ce), 64'd0);
    while (b < k && guard < 100) begin
      @(negedge clk);
      guard++;
      a_valid = 1'b0; a_data = '0; b_data = '0; start = 1'b0;
      if (a_ready) begin
        if (first_rdy < 0) first_rdy = cyc - s;
        if (b == stall_beat && bubbles > 0) begin
          bubbles--;
          #1;
          if (mxu_ce) ce_bubble++;
        end else begin
          a_valid = 1'b1; a_data = a_beats[b]; b_data = b_beats[b];
          t = cyc; b++;
          if (poke_start && b == 2) begin
            start = 1'b1; k_len = 8'd7;
          end
        end
      end
    end
    @(negedge clk);
    a_valid = 1'b0; a_data = '0; b_data = '0; start = 1'b0;
    guard = 0;
    while (!res_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("res_valid_seen", 64'(res_valid), 64'd1);
    lat = cyc - s + 1;
    tail = cyc - t;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, tail, frdy, ceb, rc0;
    logic [63:0] c_exp;

    rst = 1'b1; start = 1'b0; k_len = '0; a_valid = 1'b0;
    a_data = '0; b_data = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_ce", 64'(mxu_ce), 64'd0);
    check("rst_clr", 64'(mxu_clr), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_west_north", {mxu_west, mxu_north}, 64'd0);
    rst = 1'b0;

    // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    set_beat(0, 16'd1, 16'd3, 16'd5, 16'd6);
    set_beat(1, 16'd2, 16'd4, 16'd7, 16'd8);
    run_product(2, -1, 0, 1'b0, lat, tail, frdy, ceb);
    c_exp = pack_c(16'd19, 16'd22, 16'd43, 16'd50);
    check("k2_result", res_data, c_exp);
    check("k2_first_ready", 64'(frdy), 64'd2);
    check("k2_tail", 64'(tail), 64'd4);
    check("k2_latency", 64'(lat), 64'd8);
    @(negedge clk);
    check("k2_valid_drop", 64'(res_valid), 64'd0);
    check("k2_idle", 64'(busy), 64'd0);

    // A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]]
    set_beat(0, 16'd1, 16'd4, 16'd7, 16'd8);
    set_beat(1, 16'd2, 16'd5, 16'd9, 16'd10);
    set_beat(2, 16'd3, 16'd6, 16'd11, 16'd12);
    c_exp = pack_c(16'd58, 16'd64, 16'd139, 16'd154);
    run_product(3, -1, 0, 1'b0, lat, tail, frdy, ceb);
    check("k3_result", res_data, c_exp);
    check("k3_latency", 64'(lat), 64'd9);
    @(negedge clk);
    run_product(3, 1, 2, 1'b0, lat, tail, frdy, ceb);
    check("k3_stall_result", res_data, c_exp);
    check("k3_stall_bubble_ce", 64'(ceb), 64'd0);
    check("k3_stall_latency", 64'(lat), 64'd11);
    @(negedge clk);

    rc0 = ready_cnt;
    run_product(0, -1, 0, 1'b0, lat, tail, frdy, ceb);
    check("k0_result", res_data, 64'd0);
    check("k0_latency", 64'(lat), 64'd6);
    check("k0_no_ready", 64'(ready_cnt - rc0), 64'd0);
    @(negedge clk);

    // Back-pressure on the result, with stray start pulses in FEED and DONE.
    set_beat(0, 16'd1, 16'd3, 16'd5, 16'd6);
    set_beat(1, 16'd2, 16'd4, 16'd7, 16'd8);
    c_exp = pack_c(16'd19, 16'd22, 16'd43, 16'd50);
    res_ready = 1'b0;
    run_product(2, -1, 0, 1'b1, lat, tail, frdy, ceb);
    check("bp_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 64'(res_valid), 64'd1);
      check("bp_hold_data", res_data, c_exp);
      start = (i == 2); k_len = 8'd5;
      @(negedge clk);
    end
    start = 1'b0;
    check("bp_hold_valid_end", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 64'(res_valid), 64'd0);
    check("bp_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check("bp_start_ignored", 64'(busy), 64'd0);

    // Abort a K=4 product mid-FEED.
    for (int k = 0; k < 4; k++) set_beat(k, 16'd1000, 16'd2000, 16'd3000, 16'd4000);
    @(negedge clk);
    start = 1'b1; k_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      a_valid = 1'b1; a_data = a_beats[b]; b_data = b_beats[b];
    end
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(a_ready), 64'd0);
    check("abort_ce", 64'(mxu_ce), 64'd0);
    check("abort_res_data", res_data, 64'd0);
    check("abort_west_north", {mxu_west, mxu_north}, 64'd0);
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0; a_data = '0; b_data = '0;

    // Identity x [[9,-1],[2,3]]
    set_beat(0, 16'd1, 16'd0, 16'd9, 16'hFFFF);
    set_beat(1, 16'd0, 16'd1, 16'd2, 16'd3);
    run_product(2, -1, 0, 1'b0, lat, tail, frdy, ceb);
    check("ident_result", res_data, pack_c(16'd9, 16'hFFFF, 16'd2, 16'd3));
    check("ident_latency", 64'(lat), 64'd8);
    @(negedge clk);

    // diag(300) squared wraps to 90000 mod 2^16.
    set_beat(0, 16'd300, 16'd0, 16'd300, 16'd0);
    set_beat(1, 16'd0, 16'd300, 16'd0, 16'd300);
    run_product(2, -1, 0, 1'b0, lat, tail, frdy, ceb);
    check("ovf_result", res_data, pack_c(16'd24464, 16'd0, 16'd0, 16'd24464));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mxu_ctrl.md
# mxu_ctrl

Sequencer for the 2×2 output-stationary systolic matrix unit (`mxu`) built from `mac` PEs. It performs one matrix product C = A·B with a runtime inner dimension K:
- clears the PE accumulators;
- accepts K operand beats (A column k, B row k) over a valid/ready handshake;
- applies the diagonal input skew the array needs, then drains it;
- captures the C tile and hands it out over a second valid/ready handshake.

It sits between the operand buffers and `mxu`.

## Interface
Parameters:
- `NUM_SIZE`, 16, operand/accumulator width per element
- `GRID_SIZE`, 2, array dimension (rows = columns)
- `K_W`, 8, width of `k_len`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a product; sampled only in IDLE
- `k_len`  in  K_W  inner dimension K, sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `a_valid`  in  1  operand beat valid (A and B beats travel together)
- `a_ready`  out  1  high only in FEED
- `a_data`  in  NUM_SIZE*GRID_SIZE  A[i][k], lane i = bits [(i+1)*NUM_SIZE-1 : i*NUM_SIZE]
- `b_data`  in  NUM_SIZE*GRID_SIZE  B[k][j], lane j
- `mxu_ce`  out  1  to `mxu.ce`
- `mxu_clr`  out  1  accumulator clear; the top level drives `mxu.rst = rst | mxu_clr`
- `mxu_west`  out  NUM_SIZE*GRID_SIZE  to `mxu.west_input`
- `mxu_north`  out  NUM_SIZE*GRID_SIZE  to `mxu.north_input`
- `mxu_result`  in  NUM_SIZE*GRID_SIZE*GRID_SIZE  from `mxu.result_out`, element (i,j) at index i*GRID_SIZE+j
- `res_valid`  out  1  C tile available
- `res_ready`  in  1  consumer accepts C
- `res_data`  out  NUM_SIZE*GRID_SIZE*GRID_SIZE  registered C, same packing as `mxu_result`

## Operation
**PE contract**
- When ce=1, each `mac` forwards west→east and north→south through one register.
- When ce=1, each `mac` accumulates north×west into `result`. The accumulator is truncated to NUM_SIZE bits, two's-complement wrap; the controller neither saturates nor checks overflow.

**States**
- IDLE: `start`=1 latches `k_len` into `k_rem` and goes to CLEAR.
- CLEAR: one cycle.
  - `mxu_clr`=1, `mxu_ce`=0.
  - All skew registers are zeroed.
  - Next state is FEED, or DRAIN if K=0.
- FEED:
  - `a_ready`=1. A beat transfers when `a_valid`·`a_ready`.
  - On a transfer, `mxu_ce`=1 and `k_rem` decrements.
  - With no transfer, `mxu_ce`=0: the array and skew lines freeze. Bubbles are lossless.
  - The transfer with `k_rem`=1 moves to DRAIN.
- DRAIN: exactly 2*(GRID_SIZE-1) cycles.
  - `mxu_ce`=1; zeros are injected at all lanes.
  - Then CAPTURE. If GRID_SIZE=1, DRAIN is skipped.
- CAPTURE: one cycle.
  - `mxu_ce`=0.
  - `res_data` ← `mxu_result` at the end of the cycle.
  - Then DONE.
- DONE: `res_valid`=1 until `res_valid`·`res_ready`, then IDLE.

**Skew**
- West lane i passes through i `ce`-enabled registers: lane 0 is direct, lane 1 has one stage.
- North lane j is skewed the same way, by j stages.
- A lane's input is `a_data`/`b_data` on a transfer cycle and zero otherwise.
- Result: PE(i,j) sees A[i][k] and B[k][j] in the same `ce` cycle.

**Boundary conditions**
- `start` outside IDLE is ignored; `k_len` is not re-sampled.
- K=0 yields an all-zero C.
- `rst` at any time: IDLE immediately, `k_rem`=0, skew registers and `res_data` zeroed. No partial result is emitted.
- Back-to-back: `start` may be asserted in the cycle after the `res_valid` handshake, which is the first IDLE cycle.

**Reset values**
- All outputs are 0, including `busy`, `a_ready`, `mxu_ce`, `mxu_clr`, `res_valid`, `res_data`, `mxu_west` and `mxu_north`.

## Timing
- `start` in cycle S: CLEAR at S+1; `a_ready` first high at S+2.
- Last beat accepted in cycle T: DRAIN spans T+1 to T+2·GRID_SIZE−2, CAPTURE is at T+2·GRID_SIZE−1, and `res_valid` rises at T+2·GRID_SIZE. For GRID_SIZE=2, `res_valid` rises at T+4.
- With no stalls, total latency from `start` to `res_valid` is K+2·GRID_SIZE+2 cycles.
- `mxu_ce`, `mxu_clr` and `a_ready` are combinational from the state, and for `mxu_ce` also from `a_valid`.
- `res_data` is registered and stable while `res_valid`=1.

## Structure
- Package `mxu_pkg`:
  - `NUM_SIZE` and `GRID_SIZE` localparams, shared with `mxu`;
  - the state enum `mxu_ctrl_state_t` {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE};
  - the `DRAIN_CYCLES = 2*(GRID_SIZE-1)` constant.
- Sub-module `skew_line`:
  - parameters DEPTH and WIDTH;
  - a `ce`-enabled shift register with a synchronous clear and asynchronous `rst`; DEPTH=0 is a wire;
  - instantiated 2·GRID_SIZE times: lane i uses DEPTH=i.
- The drain counter is shared with `k_rem` or kept as a separate 3-bit counter.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], K=2, no stalls, `res_ready`=1 → `res_data` = {19,22,43,50}; `res_valid` rises exactly 4 cycles after the second beat's acceptance.
- K=3 with `a_valid` low for 2 cycles between beats 1 and 2 → same result as the unstalled run; `mxu_ce`=0 during the bubbles.
- K=0 → `res_valid` with all-zero C, 6 cycles after `start`; `a_ready` is never asserted.
- `res_ready` held low for 5 cycles in DONE → `res_valid` and `res_data` remain stable; `start` pulses during FEED and DONE are ignored.
- `rst` asserted mid-FEED of a K=4 product, then a K=2 identity×[[9,−1],[2,3]] → the second result is exactly {9,−1,2,3}, with no residue from the aborted run.
- Overflow: A=B=[[300,0],[0,300]], K=2 → C[0][0] = 90000 mod 2^16 = 24464.
